// File: rtl/sh7034_pkg.sv
// sh7034_pkg: shared internal-bus types for the SH7034 bus controller and the ibus arbiter.
//   arb_state_t  - arbiter FSM state; its encoding is the GNT code (00 none, 01 CPU, 10 DMA)
//   ibus_req_t   - one requester's view of an internal-bus access (address, data, strobes, flags)
package sh7034_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CPU_OWN = 2'b01,
    ST_DMA_OWN = 2'b10
  } arb_state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;
  typedef struct packed {
    logic [27:0] a;
    logic [31:0] d;
    logic [3:0]  ba;
    logic        we;
    logic        req;
    logic        lock;
  } ibus_req_t;
  localparam ibus_req_t IBUS_IDLE = '0;
endpackage

// File: rtl/ibus_arbiter.sv
// ibus_arbiter: two-master (CPU/DMA) arbiter in front of the internal-bus state controller.
//   i_clk, i_rst_n (async, active low), i_ce_r/i_ce_f phase enables (state moves on i_ce_r only),
//   i_res_n synchronous soft reset (active low, sampled at i_ce_r).
//   i_cpu_*/i_dma_* : requester address, write data, byte enables, we, req, lock.
//   o_cpu_do/o_dma_do, o_cpu_busy/o_dma_busy : read data and stall back to each requester.
//   o_ibus_* : owner's access forwarded to the bus controller; i_ibus_di/i_ibus_busy come back.
//   o_gnt : current owner (00 none, 01 CPU, 10 DMA).
//   Macro IBUS_ARB_ROUND_ROBIN_EN: alternate ownership instead of DMA priority with HOLD_MAX limit.
module ibus_arbiter
  import sh7034_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce_r,
  input  logic        i_ce_f,
  input  logic        i_res_n,
  input  logic [27:0] i_cpu_a,
  input  logic [31:0] i_cpu_di,
  input  logic [3:0]  i_cpu_ba,
  input  logic        i_cpu_we,
  input  logic        i_cpu_req,
  input  logic        i_cpu_lock,
  input  logic [27:0] i_dma_a,
  input  logic [31:0] i_dma_di,
  input  logic [3:0]  i_dma_ba,
  input  logic        i_dma_we,
  input  logic        i_dma_req,
  input  logic        i_dma_lock,
  output logic [31:0] o_cpu_do,
  output logic [31:0] o_dma_do,
  output logic        o_cpu_busy,
  output logic        o_dma_busy,
  output logic [27:0] o_ibus_a,
  output logic [31:0] o_ibus_do,
  output logic [3:0]  o_ibus_ba,
  output logic        o_ibus_we,
  output logic        o_ibus_req,
  output logic        o_ibus_lock,
  input  logic [31:0] i_ibus_di,
  input  logic        i_ibus_busy,
  output logic [1:0]  o_gnt
);
  arb_state_t r_state, w_next;
  ibus_req_t  w_cpu, w_dma, w_bus;
  logic       w_done, w_dma_yield, w_tie_cpu, w_unused;
  // Arbitration: IDLE picks a first owner; an owner that dropped REQ hands over at once;
  // otherwise ownership can only move at an unlocked completion.
  function automatic arb_state_t next_owner(input arb_state_t s, input logic cpu_req,
      input logic dma_req, input logic done, input logic lock, input logic dma_yield,
      input logic tie_cpu);
    logic       own_req, oth_req;
    arb_state_t oth;
    own_req = s == ST_DMA_OWN ? dma_req : cpu_req;
    oth_req = s == ST_DMA_OWN ? cpu_req : dma_req;
    oth     = s == ST_DMA_OWN ? ST_CPU_OWN : ST_DMA_OWN;
    if (s == ST_IDLE)
      return (dma_req && !(cpu_req && tie_cpu)) ? ST_DMA_OWN : cpu_req ? ST_CPU_OWN : ST_IDLE;
    if (!own_req)
      return oth_req ? oth : ST_IDLE;
    return (done && !lock && oth_req && (s == ST_CPU_OWN || dma_yield)) ? oth : s;
  endfunction
  assign w_unused = i_ce_f;
  assign w_cpu = {i_cpu_a, i_cpu_di, i_cpu_ba, i_cpu_we, i_cpu_req, i_cpu_lock};
  assign w_dma = {i_dma_a, i_dma_di, i_dma_ba, i_dma_we, i_dma_req, i_dma_lock};
  assign w_bus = r_state == ST_CPU_OWN ? w_cpu : r_state == ST_DMA_OWN ? w_dma : IBUS_IDLE;
  assign o_ibus_a    = w_bus.a;
  assign o_ibus_do   = w_bus.d;
  assign o_ibus_ba   = w_bus.ba;
  assign o_ibus_we   = w_bus.we;
  assign o_ibus_req  = w_bus.req;
  assign o_ibus_lock = w_bus.lock;
  assign o_cpu_do    = i_ibus_di;
  assign o_dma_do    = i_ibus_di;
  assign o_cpu_busy  = r_state == ST_CPU_OWN ? i_ibus_busy : i_cpu_req;
  assign o_dma_busy  = r_state == ST_DMA_OWN ? i_ibus_busy : i_dma_req;
  assign o_gnt       = r_state;
  // Only meaningful at i_ce_r, which is the only time it is consumed.
  assign w_done = w_bus.req & ~i_ibus_busy;
  assign w_next = next_owner(r_state, i_cpu_req, i_dma_req, w_done, w_bus.lock, w_dma_yield,
                             w_tie_cpu);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_state <= ST_IDLE;
    else if (i_ce_r)
      r_state <= !i_res_n ? ST_IDLE : w_next;
`ifdef IBUS_ARB_ROUND_ROBIN_EN
  logic r_last_dma;
  // An IDLE tie goes to whoever was not granted last; at a boundary the other side always wins.
  assign w_tie_cpu   = r_last_dma;
  assign w_dma_yield = 1'b1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_last_dma <= 1'b0;
    else if (i_ce_r)
      r_last_dma <= !i_res_n ? 1'b0
                  : (w_next != r_state && w_next != ST_IDLE) ? (w_next == ST_DMA_OWN) : r_last_dma;
`else
  logic [2:0] r_hold, w_hold_inc;
  assign w_hold_inc = &r_hold ? r_hold : r_hold + 3'd1;
  assign w_tie_cpu  = 1'b0;
  // The completion being counted is included, so DMA gets exactly HOLD_MAX accesses.
  assign w_dma_yield = (HOLD_MAX != 0) && (w_hold_inc == 3'(HOLD_MAX));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_hold <= '0;
    else if (i_ce_r)
      r_hold <= (!i_res_n || w_next != r_state || !i_cpu_req) ? 3'd0
              : (w_done && r_state == ST_DMA_OWN) ? w_hold_inc : r_hold;
`endif
endmodule

// File: tb/tb_ibus_arbiter.sv
module tb_ibus_arbiter;
  import sh7034_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, ce_r = 1'b1, ce_f = 1'b0, res_n = 1'b1;
  logic [27:0] cpu_a = '0, dma_a = '0;
  logic [31:0] cpu_di = '0, dma_di = '0;
  logic [3:0]  cpu_ba = '0, dma_ba = '0;
  logic        cpu_we = 1'b0, cpu_req = 1'b0, cpu_lock = 1'b0;
  logic        dma_we = 1'b0, dma_req = 1'b0, dma_lock = 1'b0;
  logic [31:0] cpu_do, dma_do, ibus_do, ibus_di;
  logic        cpu_busy, dma_busy, ibus_we, ibus_req, ibus_lock;
  logic        ibus_busy = 1'b0;
  logic [27:0] ibus_a;
  logic [3:0]  ibus_ba;
  logic [1:0]  gnt;
  typedef struct {
    logic [1:0]  gnt;
    logic [27:0] a;
    logic        we;
    logic [3:0]  ba;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  int errs = 0, checks = 0, wait_n = 0;

  ibus_arbiter #(.HOLD_MAX(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce_r(ce_r), .i_ce_f(ce_f), .i_res_n(res_n),
    .i_cpu_a(cpu_a), .i_cpu_di(cpu_di), .i_cpu_ba(cpu_ba), .i_cpu_we(cpu_we),
    .i_cpu_req(cpu_req), .i_cpu_lock(cpu_lock),
    .i_dma_a(dma_a), .i_dma_di(dma_di), .i_dma_ba(dma_ba), .i_dma_we(dma_we),
    .i_dma_req(dma_req), .i_dma_lock(dma_lock),
    .o_cpu_do(cpu_do), .o_dma_do(dma_do), .o_cpu_busy(cpu_busy), .o_dma_busy(dma_busy),
    .o_ibus_a(ibus_a), .o_ibus_do(ibus_do), .o_ibus_ba(ibus_ba), .o_ibus_we(ibus_we),
    .o_ibus_req(ibus_req), .o_ibus_lock(ibus_lock),
    .i_ibus_di(ibus_di), .i_ibus_busy(ibus_busy), .o_gnt(gnt)
  );

  always #5 clk = ~clk;

  // Bus controller stand-in: stalls each access for wait_n cycles, read data derived from address.
  assign ibus_di = {4'hA, ibus_a};
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #3;
      if (ibus_req && cnt < wait_n) begin
        ibus_busy = 1'b1;
        cnt++;
      end else begin
        ibus_busy = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: every completing access is matched against the next expected one.
  initial begin
    exp_t        e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (rst_n && res_n && ce_r && ibus_req && !ibus_busy) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_completion: gnt=%b a=%h", gnt, ibus_a);
        end else begin
          e = q.pop_front();
          d = e.we ? ibus_do : (gnt == GNT_CPU ? cpu_do : dma_do);
          if (gnt !== e.gnt || ibus_a !== e.a || ibus_we !== e.we || ibus_ba !== e.ba || d !== e.d) begin
            errs++;
            $display("FAIL completion: got gnt=%b a=%h we=%b ba=%h d=%h expected gnt=%b a=%h we=%b ba=%h d=%h",
                     gnt, ibus_a, ibus_we, ibus_ba, d, e.gnt, e.a, e.we, e.ba, e.d);
          end
        end
      end
    end
  end

  task automatic expect_acc(input logic [1:0] g, input logic [27:0] a, input logic we);
    exp_t e;
    e.gnt = g;
    e.a   = a;
    e.we  = we;
    e.ba  = g == GNT_CPU ? 4'hF : 4'h3;
    e.d   = we ? {4'hB, a} : {4'hA, a};
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit dma, input logic req, input logic [27:0] a, input logic lk,
                       input logic we);
    if (dma) begin
      dma_req = req; dma_a = a; dma_lock = lk; dma_we = we; dma_ba = 4'h3;
      dma_di = we ? {4'hB, a} : 32'h0;
    end else begin
      cpu_req = req; cpu_a = a; cpu_lock = lk; cpu_we = we; cpu_ba = 4'hF;
      cpu_di = we ? {4'hB, a} : 32'h0;
    end
  endtask

  // One requester issuing n consecutive accesses; counts cycles it was owner and stalled.
  task automatic run_req(input bit dma, input int n, input logic [27:0] base, input bit lk,
                         input bit we, output int bcyc);
    logic [1:0] g;
    int         t;
    bit         done;
    g = dma ? GNT_DMA : GNT_CPU;
    bcyc = 0;
    for (int i = 0; i < n; i++) begin
      drive(dma, 1'b1, base + 28'(4 * i), lk && (i < n - 1), we);
      t = 0;
      done = 1'b0;
      while (!done && t < 200) begin
        @(negedge clk);
        t++;
        if (gnt == g) begin
          if (dma ? dma_busy : cpu_busy) bcyc++;
          done = ibus_req && !ibus_busy;
        end
      end
      if (!done) begin
        checks++;
        errs++;
        $display("FAIL req_timeout: %s access %0d never completed", dma ? "dma" : "cpu", i);
      end
      @(posedge clk);
      #1;
    end
    drive(dma, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_cond(input logic [1:0] g, input bit need_done, input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(gnt == g && (!need_done || (ibus_req && !ibus_busy))) && t < 200);
    if (t >= 200) begin
      checks++;
      errs++;
      $display("FAIL %s: timeout waiting for gnt=%b", name, g);
    end
  endtask

  task automatic soft_reset();
    @(posedge clk); #1 res_n = 1'b0;
    @(posedge clk); #1 res_n = 1'b1;
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int bc, bd, t;
    // Reset with a locked CPU request pending: nothing may leak onto the bus.
    drive(1'b0, 1'b1, 28'h123, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'(GNT_NONE));
    chk("rst_ibus_req", 32'(ibus_req), 0);
    chk("rst_ibus_lock", 32'(ibus_lock), 0);
    chk("rst_ibus_a", 32'(ibus_a), 0);
    chk("rst_cpu_busy", 32'(cpu_busy), 1);
    chk("rst_dma_busy", 32'(dma_busy), 0);
    // Without CE_R the FSM must not move.
    ce_r = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ce_r_gate", 32'(gnt), 32'(GNT_NONE));
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    ce_r = 1'b1;
    gap();
    // CPU read with two wait states.
    wait_n = 2;
    expect_acc(GNT_CPU, 28'h0000100, 1'b0);
    fork
      run_req(1'b0, 1, 28'h0000100, 1'b0, 1'b0, bc);
      begin
        wait_cond(GNT_CPU, 1'b0, "cpu_grant");
        chk("cpu_read_dma_busy", 32'(dma_busy), 0);
      end
    join
    chk("cpu_busy_cycles", 32'(bc), 2);
    gap();
    // DMA arrives mid CPU access: hand-over on the completing edge, CPU stalls meanwhile.
    expect_acc(GNT_CPU, 28'h200, 1'b0);
    expect_acc(GNT_DMA, 28'h800, 1'b1);
    expect_acc(GNT_CPU, 28'h204, 1'b0);
    fork
      run_req(1'b0, 2, 28'h200, 1'b0, 1'b0, bc);
      begin
        repeat (2) @(posedge clk);
        #1;
        run_req(1'b1, 1, 28'h800, 1'b0, 1'b1, bd);
      end
      begin
        wait_cond(GNT_CPU, 1'b1, "cpu_complete");
        @(negedge clk);
        chk("switch_gnt", 32'(gnt), 32'(GNT_DMA));
        chk("switch_no_bubble", 32'(ibus_req), 1);
        chk("switch_cpu_busy", 32'(cpu_busy), 1);
      end
    join
    gap();
    // Locked read-modify-write keeps the bus despite pending DMA.
    expect_acc(GNT_CPU, 28'h300, 1'b0);
    expect_acc(GNT_CPU, 28'h304, 1'b0);
    expect_acc(GNT_DMA, 28'h900, 1'b0);
    fork
      run_req(1'b0, 2, 28'h300, 1'b1, 1'b0, bc);
      begin
        repeat (2) @(posedge clk);
        #1;
        run_req(1'b1, 1, 28'h900, 1'b0, 1'b0, bd);
      end
      begin
        wait_cond(GNT_CPU, 1'b0, "lock_grant");
        chk("lock_forward", 32'(ibus_lock), 1);
      end
    join
    gap();
    // Soft reset in the middle of a DMA access abandons it; DMA is regranted from IDLE.
    wait_n = 5;
    expect_acc(GNT_DMA, 28'hA00, 1'b1);
    fork
      run_req(1'b1, 1, 28'hA00, 1'b0, 1'b1, bd);
      begin
        wait_cond(GNT_DMA, 1'b0, "dma_grant");
        repeat (2) @(posedge clk);
        #1 res_n = 1'b0;
        @(posedge clk);
        #1 res_n = 1'b1;
        @(negedge clk);
        chk("res_gnt", 32'(gnt), 32'(GNT_NONE));
        chk("res_ibus_req", 32'(ibus_req), 0);
        @(negedge clk);
        chk("res_regrant", 32'(gnt), 32'(GNT_DMA));
      end
    join
    gap();
    // Both request two accesses from IDLE.
    soft_reset();
    wait_n = 1;
`ifdef IBUS_ARB_ROUND_ROBIN_EN
    expect_acc(GNT_DMA, 28'hB00, 1'b0);
    expect_acc(GNT_CPU, 28'h400, 1'b0);
    expect_acc(GNT_DMA, 28'hB04, 1'b0);
    expect_acc(GNT_CPU, 28'h404, 1'b0);
`else
    expect_acc(GNT_DMA, 28'hB00, 1'b0);
    expect_acc(GNT_DMA, 28'hB04, 1'b0);
    expect_acc(GNT_CPU, 28'h400, 1'b0);
    expect_acc(GNT_CPU, 28'h404, 1'b0);
`endif
    fork
      run_req(1'b0, 2, 28'h400, 1'b0, 1'b0, bc);
      run_req(1'b1, 2, 28'hB00, 1'b0, 1'b0, bd);
    join
    gap();
    // Continuous contention: CPU 2 accesses, DMA 8.
`ifdef IBUS_ARB_ROUND_ROBIN_EN
    expect_acc(GNT_DMA, 28'hC00, 1'b0);
    expect_acc(GNT_CPU, 28'h500, 1'b0);
    expect_acc(GNT_DMA, 28'hC04, 1'b0);
    expect_acc(GNT_CPU, 28'h504, 1'b0);
    for (int i = 2; i < 8; i++) expect_acc(GNT_DMA, 28'hC00 + 28'(4 * i), 1'b0);
`else
    for (int i = 0; i < 4; i++) expect_acc(GNT_DMA, 28'hC00 + 28'(4 * i), 1'b0);
    expect_acc(GNT_CPU, 28'h500, 1'b0);
    for (int i = 4; i < 8; i++) expect_acc(GNT_DMA, 28'hC00 + 28'(4 * i), 1'b0);
    expect_acc(GNT_CPU, 28'h504, 1'b0);
`endif
    fork
      run_req(1'b0, 2, 28'h500, 1'b0, 1'b0, bc);
      run_req(1'b1, 8, 28'hC00, 1'b0, 1'b0, bd);
    join
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ibus_arbiter.md
IBUS_ARBITER -- requirements
Module: ibus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, max consecutive completed DMA accesses while CPU waits (0 = unlimited).
REQ-002 CLK  in  1  system clock.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 CE_R / CE_F  in  1 each  rising/falling phase enables; all state changes occur on CE_R only.
REQ-005 RES_N  in  1  synchronous soft reset, active low.
REQ-006 CPU_A / DMA_A  in  28 each  requester address.
REQ-007 CPU_DI / DMA_DI  in  32 each  requester write data.
REQ-008 CPU_BA / DMA_BA  in  4 each  byte enables.
REQ-009 CPU_WE / DMA_WE, CPU_REQ / DMA_REQ, CPU_LOCK / DMA_LOCK  in  1 each  write, request, locked-sequence flags.
REQ-010 CPU_DO / DMA_DO  out  32 each  read data, both driven from IBUS_DI.
REQ-011 CPU_BUSY / DMA_BUSY  out  1 each  per-requester stall.
REQ-012 IBUS_A 28, IBUS_DO 32, IBUS_BA 4, IBUS_WE 1, IBUS_REQ 1, IBUS_LOCK 1  out  forwarded to bus state controller.
REQ-013 IBUS_DI  in  32, IBUS_BUSY  in  1  read data and stall from bus state controller.
REQ-014 GNT  out  2  owner: 00 none, 01 CPU, 10 DMA.

Function
REQ-015 FSM states IDLE, CPU_OWN, DMA_OWN; GNT encodes the state.
REQ-016 IDLE: at CE_R, DMA_REQ -> DMA_OWN; else CPU_REQ -> CPU_OWN; else stay.
REQ-017 Owned state: owner's A/DI/BA/WE/REQ/LOCK forwarded combinationally to IBUS_*; in IDLE, IBUS_REQ=0, IBUS_LOCK=0, other IBUS_* = 0.
REQ-018 Owner BUSY = IBUS_BUSY; non-owner BUSY = its REQ; in IDLE, both BUSY = own REQ.
REQ-019 Access completes at a CE_R with IBUS_REQ=1 and IBUS_BUSY=0; arbitration occurs only at completion or when owner REQ=0.
REQ-020 Owner LOCK=1 at completion: ownership retained regardless of other request.
REQ-021 At unlocked completion: other requester's REQ=1 and arbitration rule selects it -> switch owner same edge; owner REQ=1 otherwise -> retain; neither -> IDLE.
REQ-022 Fixed-priority rule: CPU_OWN yields to pending DMA at every unlocked boundary; DMA_OWN yields to pending CPU only when hold counter = HOLD_MAX (HOLD_MAX != 0).
REQ-023 Hold counter 3-bit saturating: clears on entry to any state and when CPU_REQ=0; increments on each completed DMA access while CPU_REQ=1.
REQ-024 Owner drops REQ with no access outstanding: -> other requester if requesting, else IDLE, on that CE_R.
REQ-025 Simultaneous first requests in IDLE: DMA wins (fixed) or last-loser wins (REQ-033).
REQ-026 Switch-over adds no bubble: new owner's request appears on IBUS_REQ the cycle after the completing CE_R.

Reset
REQ-027 RST_N low: state IDLE, GNT=00, hold counter 0, last-owner flag CPU, IBUS_REQ=0, IBUS_LOCK=0, all IBUS_* outputs 0.
REQ-028 RES_N low at CE_R: same values as REQ-027, even mid-access; any IBUS access in flight is abandoned.
REQ-029 Outputs derived combinationally from IBUS_DI/IBUS_BUSY carry no reset value of their own.

Configuration
REQ-030 Macro IBUS_ARB_ROUND_ROBIN_EN selects the arbitration rule.
REQ-031 Undefined: fixed DMA-over-CPU priority with HOLD_MAX limit (REQ-022, REQ-023).
REQ-032 Defined: at each unlocked boundary with both requesting, ownership alternates; HOLD_MAX and hold counter are unused.
REQ-033 Defined: IDLE tie goes to the requester not granted last; a last-owner flag is updated on each grant.

Structure
REQ-034 GNT encoding and the FSM state enum go in SH7034_PKG, alongside the bus controller types.
REQ-035 Single flat module; no sub-module; next-owner selection in one function.

Verification
REQ-036 CPU read 0x0000100, IBUS_BUSY high 2 CE_R -> GNT=01, CPU_BUSY high 2 CE_R, CPU_DO = IBUS_DI at completion, DMA_BUSY=0.
REQ-037 CPU access in flight, DMA_REQ rises -> CPU completes, GNT=10 on the completing edge, CPU_BUSY high until DMA completes.
REQ-038 HOLD_MAX=4, both requesting continuously (fixed mode) -> 4 DMA completions then 1 CPU, repeating.
REQ-039 CPU_LOCK=1 over 2-access read-modify-write, DMA_REQ pending -> both CPU accesses complete before GNT=10.
REQ-040 ROUND_ROBIN_EN defined, both requesting from IDLE -> grants DMA, CPU, DMA, CPU at successive completions.
REQ-041 RES_N pulsed low mid DMA access -> next cycle GNT=00, IBUS_REQ=0; after release DMA regrants from IDLE.
